adder_arbiter: RTL and testbench

Round-robin arbiter that shares a single `width`-bit adder among `NREQ` requesters (PC increment, branch-target, load/store address generation, ALU add path) through valid/ready handshakes. One request is granted per cycle. Its sum is captured in a single registered output stage, tagged with the requester index, and held until the consumer accepts it. The block sits between the requesting pipeline stages and their writeback/consume points, and replaces per-stage adders where area matters.

---
 rtl/adder_arbiter.sv | 125 ++++++++++++
 tb/tb_adder_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one width-bit adder among NREQ requesters; define ADDER_ARB_OVF_EN to add res_ovf.
// Latency: a grant on edge N is visible as res_valid after edge N (one registered stage).
// Backpressure: no grant while the output holds an unaccepted result; drain and refill share an edge.
module adder_arbiter #(
    parameter int width = 32,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*width-1:0]   req_a,
    input  logic [NREQ*width-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [width-1:0]        res_sum,
    output logic [2:0]              res_id
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                    res_ovf
`endif
);

    logic [2:0]       ptr_q, ptr_d;
    logic             res_valid_q, res_valid_d;
    logic [width-1:0] res_sum_q, res_sum_d;
    logic [2:0]       res_id_q, res_id_d;
    logic             res_ovf_d;

    logic             can_accept;
    logic             gnt_vld;
    logic [2:0]       gnt_id;
    logic [2:0]       gnt_ptr;
    logic [NREQ-1:0]  gnt_vec;
    logic [width-1:0] a_sel, b_sel, sum_sel;

    always_comb begin
        can_accept = !res_valid_q || res_ready;
        gnt_vld    = 1'b0;
        gnt_id     = 3'd0;
        gnt_ptr    = 3'd0;
        gnt_vec    = '0;
        a_sel      = '0;
        b_sel      = '0;
        // Two passes give the circular search ptr..NREQ-1 then 0..ptr-1 with constant indices.
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_vld && i >= int'(ptr_q) && req_valid[i]) begin
                gnt_vld    = 1'b1;
                gnt_id     = 3'(i);
                gnt_ptr    = (i == NREQ - 1) ? 3'd0 : 3'(i + 1);
                gnt_vec[i] = 1'b1;
                a_sel      = req_a[i*width +: width];
                b_sel      = req_b[i*width +: width];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_vld && i < int'(ptr_q) && req_valid[i]) begin
                gnt_vld    = 1'b1;
                gnt_id     = 3'(i);
                gnt_ptr    = 3'(i + 1);
                gnt_vec[i] = 1'b1;
                a_sel      = req_a[i*width +: width];
                b_sel      = req_b[i*width +: width];
            end
        end
        if (!can_accept || reset) begin
            gnt_vld = 1'b0;
            gnt_vec = '0;
        end
        sum_sel   = a_sel + b_sel;
        res_ovf_d = (a_sel[width-1] == b_sel[width-1]) && (sum_sel[width-1] != a_sel[width-1]);
    end

    always_comb begin
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
        if (gnt_vld) begin
            ptr_d       = gnt_ptr;
            res_valid_d = 1'b1;
            res_sum_d   = sum_sel;
            res_id_d    = gnt_id;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= 3'd0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= 3'd0;
        end else begin
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
        end
    end

`ifdef ADDER_ARB_OVF_EN
    logic res_ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            res_ovf_q <= 1'b0;
        end else if (gnt_vld) begin
            res_ovf_q <= res_ovf_d;
        end
    end

    assign res_ovf = res_ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = res_ovf_d;
`endif

    assign req_ready = gnt_vec;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (4 requesters, 32-bit).
module tb_adder_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_sum;
    logic [2:0]       res_id;
`ifdef ADDER_ARB_OVF_EN
    logic             res_ovf;
`endif

    int total;
    int bad;

    adder_arbiter #(.width(W), .NREQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id)
`ifdef ADDER_ARB_OVF_EN
        ,
        .res_ovf   (res_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
            total++;
            if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
            total++;
            if (res_sum !== 32'h0 || res_id !== 3'd0) begin bad++; $display("FAIL reset_sum_id got=%h/%0d want=0/0", res_sum, res_id); end
        end
        reset = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b want=0001", req_ready); end
        step();
        total++;
        if (res_valid !== 1'b1 || res_id !== 3'd0) begin bad++; $display("FAIL reset_first_result got=%b/%0d want=1/0", res_valid, res_id); end
        req_valid = 4'b0000;
        step();
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", res_valid); end
    endtask

    task automatic test_single();
        // ptr is 1 here; requester 2 is the only one asking.
        set_req(2, 32'h0000_0004, 32'h0040_0000);
        req_valid = 4'b0100;
        res_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", req_ready); end
        step();
        req_valid = 4'b0000;
        total++;
        if (res_valid !== 1'b1 || res_sum !== 32'h0040_0004 || res_id !== 3'd2) begin
            bad++; $display("FAIL single_result got=%b/%h/%0d want=1/00400004/2", res_valid, res_sum, res_id);
        end
        step();
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", res_valid); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] exp_sum [N];
        exp_sum[0] = 32'h1000_0005;
        exp_sum[1] = 32'h2000_0006;
        exp_sum[2] = 32'h3000_0007;
        exp_sum[3] = 32'h4000_0008;
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 32'h1000_0000, 32'd5);
        set_req(1, 32'h2000_0000, 32'd6);
        set_req(2, 32'h3000_0000, 32'd7);
        set_req(3, 32'h4000_0000, 32'd8);
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (req_ready !== (4'b0001 << (k % N))) begin bad++; $display("FAIL rr_grant_%0d got=%b want_id=%0d", k, req_ready, k % N); end
            step();
            total++;
            if (res_valid !== 1'b1 || res_id !== 3'(k % N) || res_sum !== exp_sum[k % N]) begin
                bad++; $display("FAIL rr_result_%0d got=%b/%0d/%h want=1/%0d/%h", k, res_valid, res_id, res_sum, k % N, exp_sum[k % N]);
            end
        end
    endtask

    task automatic test_backpressure();
        // Result from requester 0 is held; ptr is 1.
        req_valid = 4'b0010;
        res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready_%0d got=%b want=0000", c, req_ready); end
            step();
            total++;
            if (res_valid !== 1'b1 || res_id !== 3'd0 || res_sum !== 32'h1000_0005) begin
                bad++; $display("FAIL bp_hold_%0d got=%b/%0d/%h want=1/0/10000005", c, res_valid, res_id, res_sum);
            end
        end
        res_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b want=0010", req_ready); end
        step();
        req_valid = 4'b0000;
        total++;
        if (res_valid !== 1'b1 || res_id !== 3'd1 || res_sum !== 32'h2000_0006) begin
            bad++; $display("FAIL bp_refill got=%b/%0d/%h want=1/1/20000006", res_valid, res_id, res_sum);
        end
        step();
    endtask

    task automatic test_wrap();
        // ptr is 2: requester 2 wraps the sum, requester 3 overflows signed, then ptr wraps to 0.
        set_req(2, 32'hFFFF_FFFF, 32'h0000_0001);
        req_valid = 4'b0100;
        step();
        total++;
        if (res_sum !== 32'h0 || res_id !== 3'd2) begin bad++; $display("FAIL wrap_sum got=%h/%0d want=0/2", res_sum, res_id); end
`ifdef ADDER_ARB_OVF_EN
        total++;
        if (res_ovf !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b want=0", res_ovf); end
`endif
        set_req(3, 32'h7FFF_FFFF, 32'h0000_0001);
        req_valid = 4'b1000;
        step();
        total++;
        if (res_sum !== 32'h8000_0000 || res_id !== 3'd3) begin bad++; $display("FAIL ovf_sum got=%h/%0d want=80000000/3", res_sum, res_id); end
`ifdef ADDER_ARB_OVF_EN
        total++;
        if (res_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", res_ovf); end
`endif
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL ptr_wrap got=%b want=0001", req_ready); end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid();
        // Grant requester 2 so ptr becomes 3, then hold the result.
        req_valid = 4'b0100;
        res_ready = 1'b1;
        step();
        req_valid = 4'b0000;
        res_ready = 1'b0;
        #1;
        total++;
        if (res_valid !== 1'b1 || res_id !== 3'd2) begin bad++; $display("FAIL mid_setup got=%b/%0d want=1/2", res_valid, res_id); end
        reset = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready_in_reset got=%b want=0000", req_ready); end
        step();
        reset = 1'b0;
        total++;
        if (res_valid !== 1'b0 || res_id !== 3'd0 || res_sum !== 32'h0) begin
            bad++; $display("FAIL mid_cleared got=%b/%0d/%h want=0/0/0", res_valid, res_id, res_sum);
        end
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_next_grant got=%b want=0001", req_ready); end
        step();
        total++;
        if (res_valid !== 1'b1 || res_id !== 3'd0) begin bad++; $display("FAIL mid_next_result got=%b/%0d want=1/0", res_valid, res_id); end
        req_valid = 4'b0000;
        step();
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
